// File: rtl/mem_stage_if.sv
// Data-memory request/acknowledge bus between the MEM stage and data memory.
//   dmem_req   : access request, held until ack or abort
//   dmem_we    : 1=store, 0=load (valid while dmem_req)
//   dmem_addr  : word-aligned byte address (valid while dmem_req)
//   dmem_wdata : store data (valid while dmem_req)
//   dmem_rdata : load data, sampled on dmem_ack
//   dmem_ack   : one-cycle completion pulse from memory
interface mem_stage_if #(
  parameter int DATA_W = 32
);
  logic              dmem_req;
  logic              dmem_we;
  logic [DATA_W-1:0] dmem_addr;
  logic [DATA_W-1:0] dmem_wdata;
  logic [DATA_W-1:0] dmem_rdata;
  logic              dmem_ack;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_rdata, dmem_ack
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_rdata, dmem_ack
  );
endinterface

// File: rtl/mem_stage.sv
// MEM pipeline stage: issues loads/stores on the req/ack data bus, stalls the
// upstream pipeline while an access is outstanding, produces the MEM/WB
// register set and resolves branch-taken.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   res, write_data_ex,
//   write_register_ex,
//   zero, m_MEM, wb_MEM   EX/MEM register outputs
//   dmem                  data-memory bus (master side)
//   stall_mem             hold PC, IF/ID, ID/EX, EX/MEM
//   pc_src                branch taken
//   wb_WB, mem_to_reg_wb,
//   rd_WB, read_data_wb,
//   alu_res_wb            MEM/WB register set
//   write_data_reg        write-back value, also fed to EX forwarding
//   align_err, bus_err    one-cycle error pulses
//
// state | meaning
// IDLE  | no access outstanding; non-memory ops pass straight to MEM/WB
// WAIT  | request on the bus, waiting for dmem_ack or timeout
module mem_stage #(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] res,
  input  logic [DATA_W-1:0] write_data_ex,
  input  logic [4:0]        write_register_ex,
  input  logic              zero,
  input  logic [2:0]        m_MEM,
  input  logic [1:0]        wb_MEM,
  mem_stage_if.master       dmem,
  output logic              stall_mem,
  output logic              pc_src,
  output logic              wb_WB,
  output logic              mem_to_reg_wb,
  output logic [4:0]        rd_WB,
  output logic [DATA_W-1:0] read_data_wb,
  output logic [DATA_W-1:0] alu_res_wb,
  output logic [DATA_W-1:0] write_data_reg,
  output logic              align_err,
  output logic              bus_err
);

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t state_q, state_d;

  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        cap_wb_q, cap_wb_d;
  logic [4:0]        cap_rd_q, cap_rd_d;
  logic [DATA_W-1:0] cap_res_q, cap_res_d;
  logic              wb_q, wb_d;
  logic              m2r_q, m2r_d;
  logic [4:0]        rd_q, rd_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [DATA_W-1:0] alu_q, alu_d;
  logic              align_q, align_d;
  logic              bus_q, bus_d;

  logic memop, misaligned, issue, ack_hit, timeout_hit;

  assign memop       = m_MEM[1] | m_MEM[0];
  assign misaligned  = res[1:0] != 2'b00;
  assign issue       = (state_q == IDLE) & memop & ~misaligned;
  // ack in IDLE is ignored; ack beats a coincident timeout
  assign ack_hit     = (state_q == WAIT) & dmem.dmem_ack;
  assign timeout_hit = (state_q == WAIT) & ~dmem.dmem_ack & (cnt_q == CNT_LAST);

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (issue) state_d = WAIT;
      WAIT: if (ack_hit || timeout_hit) state_d = IDLE;
    endcase
  end

  // outputs: an aborted access releases the stall so the faulting op is
  // dropped rather than re-issued
  always_comb begin
    stall_mem = issue | ((state_q == WAIT) & ~dmem.dmem_ack & ~timeout_hit);
    pc_src    = m_MEM[2] & zero & ~stall_mem;
  end

  // datapath next values; MEM/WB control defaults to a bubble
  always_comb begin
    req_d     = req_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    cnt_d     = cnt_q;
    cap_wb_d  = cap_wb_q;
    cap_rd_d  = cap_rd_q;
    cap_res_d = cap_res_q;
    wb_d      = 1'b0;
    m2r_d     = 1'b0;
    rd_d      = rd_q;
    rdata_d   = rdata_q;
    alu_d     = alu_q;
    align_d   = 1'b0;
    bus_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!memop) begin
          wb_d  = wb_MEM[1];
          m2r_d = wb_MEM[0];
          rd_d  = write_register_ex;
          alu_d = res;
        end else if (misaligned) begin
          align_d = 1'b1;
        end else begin
          req_d     = 1'b1;
          we_d      = m_MEM[0];
          addr_d    = {res[DATA_W-1:2], 2'b00};
          wdata_d   = write_data_ex;
          cnt_d     = '0;
          cap_wb_d  = wb_MEM;
          cap_rd_d  = write_register_ex;
          cap_res_d = res;
        end
      end
      WAIT: begin
        if (ack_hit) begin
          req_d = 1'b0;
          wb_d  = cap_wb_q[1];
          m2r_d = cap_wb_q[0];
          rd_d  = cap_rd_q;
          alu_d = cap_res_q;
          if (!we_q) rdata_d = dmem.dmem_rdata;
        end else if (timeout_hit) begin
          req_d = 1'b0;
          bus_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      cnt_q     <= '0;
      cap_wb_q  <= '0;
      cap_rd_q  <= '0;
      cap_res_q <= '0;
      wb_q      <= 1'b0;
      m2r_q     <= 1'b0;
      rd_q      <= '0;
      rdata_q   <= '0;
      alu_q     <= '0;
      align_q   <= 1'b0;
      bus_q     <= 1'b0;
    end else begin
      req_q     <= req_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      cnt_q     <= cnt_d;
      cap_wb_q  <= cap_wb_d;
      cap_rd_q  <= cap_rd_d;
      cap_res_q <= cap_res_d;
      wb_q      <= wb_d;
      m2r_q     <= m2r_d;
      rd_q      <= rd_d;
      rdata_q   <= rdata_d;
      alu_q     <= alu_d;
      align_q   <= align_d;
      bus_q     <= bus_d;
    end
  end

  assign dmem.dmem_req   = req_q;
  assign dmem.dmem_we    = we_q;
  assign dmem.dmem_addr  = addr_q;
  assign dmem.dmem_wdata = wdata_q;

  assign wb_WB          = wb_q;
  assign mem_to_reg_wb  = m2r_q;
  assign rd_WB          = rd_q;
  assign read_data_wb   = rdata_q;
  assign alu_res_wb     = alu_q;
  assign write_data_reg = m2r_q ? rdata_q : alu_q;
  assign align_err      = align_q;
  assign bus_err        = bus_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: a vector table for single-cycle (non-stalling)
// behaviour plus scripted load/store/timeout/branch/reset sequences.
module tb_mem_stage;

  logic        clk;
  logic        rst_n;
  logic [31:0] res;
  logic [31:0] write_data_ex;
  logic [4:0]  write_register_ex;
  logic        zero;
  logic [2:0]  m_MEM;
  logic [1:0]  wb_MEM;
  logic        stall_mem, pc_src, wb_WB, mem_to_reg_wb;
  logic [4:0]  rd_WB;
  logic [31:0] read_data_wb, alu_res_wb, write_data_reg;
  logic        align_err, bus_err;

  int n_chk  = 0;
  int n_fail = 0;

  mem_stage_if #(.DATA_W(32)) bus ();

  mem_stage #(.DATA_W(32), .TIMEOUT(16), .CNT_W(5)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .res               (res),
    .write_data_ex     (write_data_ex),
    .write_register_ex (write_register_ex),
    .zero              (zero),
    .m_MEM             (m_MEM),
    .wb_MEM            (wb_MEM),
    .dmem              (bus),
    .stall_mem         (stall_mem),
    .pc_src            (pc_src),
    .wb_WB             (wb_WB),
    .mem_to_reg_wb     (mem_to_reg_wb),
    .rd_WB             (rd_WB),
    .read_data_wb      (read_data_wb),
    .alu_res_wb        (alu_res_wb),
    .write_data_reg    (write_data_reg),
    .align_err         (align_err),
    .bus_err           (bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    logic [2:0]  m;
    logic [1:0]  wb;
    logic        zero;
    logic        ack;
    logic        e_stall;
    logic        e_pc;
    logic        e_wb;
    logic        e_m2r;
    logic [4:0]  e_rd;
    logic [31:0] e_alu;
    logic [31:0] e_wdr;
    logic        e_align;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_nop();
    res               = 32'h0;
    write_data_ex     = 32'h0;
    write_register_ex = 5'd0;
    zero              = 1'b0;
    m_MEM             = 3'b000;
    wb_MEM            = 2'b00;
  endtask

  task automatic drive_op(input logic [31:0] r, input logic [31:0] wd, input logic [4:0] rd,
                          input logic [2:0] m, input logic [1:0] wb, input logic z);
    res               = r;
    write_data_ex     = wd;
    write_register_ex = rd;
    m_MEM             = m;
    wb_MEM            = wb;
    zero              = z;
  endtask

  initial begin
    rst_n          = 1'b0;
    bus.dmem_ack   = 1'b0;
    bus.dmem_rdata = 32'h0;
    drive_nop();

    vecs[0] = '{32'h0000_0010, 5'd5,  3'b000, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd5,  32'h0000_0010, 32'h0000_0010, 1'b0};
    vecs[1] = '{32'hABCD_0003, 5'd31, 3'b000, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd31, 32'hABCD_0003, 32'h0000_0000, 1'b0};
    vecs[2] = '{32'h0000_0040, 5'd0,  3'b100, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0,  32'h0000_0040, 32'h0000_0040, 1'b0};
    vecs[3] = '{32'h0000_0044, 5'd3,  3'b100, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd3,  32'h0000_0044, 32'h0000_0044, 1'b0};
    vecs[4] = '{32'h0000_0102, 5'd8,  3'b010, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd3,  32'h0000_0044, 32'h0000_0044, 1'b1};
    vecs[5] = '{32'h0000_0021, 5'd9,  3'b001, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd3,  32'h0000_0044, 32'h0000_0044, 1'b1};
    vecs[6] = '{32'h0000_0003, 5'd10, 3'b011, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd3,  32'h0000_0044, 32'h0000_0044, 1'b1};
    vecs[7] = '{32'h0000_0007, 5'd12, 3'b000, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd12, 32'h0000_0007, 32'h0000_0007, 1'b0};

    // reset values
    #12;
    chk("rst_req",   bus.dmem_req,   0);
    chk("rst_we",    bus.dmem_we,    0);
    chk("rst_addr",  bus.dmem_addr,  0);
    chk("rst_wdata", bus.dmem_wdata, 0);
    chk("rst_wb",    wb_WB,          0);
    chk("rst_m2r",   mem_to_reg_wb,  0);
    chk("rst_rd",    rd_WB,          0);
    chk("rst_rdata", read_data_wb,   0);
    chk("rst_alu",   alu_res_wb,     0);
    chk("rst_align", align_err,      0);
    chk("rst_bus",   bus_err,        0);
    rst_n = 1'b1;
    tick();

    // single-cycle vector table; ack pulses here must be ignored in IDLE
    bus.dmem_rdata = 32'hFFFF_FFFF;
    for (int i = 0; i < 8; i++) begin
      drive_op(vecs[i].res, 32'h5555_AAAA, vecs[i].rd, vecs[i].m, vecs[i].wb, vecs[i].zero);
      bus.dmem_ack = vecs[i].ack;
      #1;
      chk($sformatf("v%0d_stall", i), stall_mem, vecs[i].e_stall);
      chk($sformatf("v%0d_pc", i),    pc_src,    vecs[i].e_pc);
      tick();
      chk($sformatf("v%0d_wb", i),    wb_WB,          vecs[i].e_wb);
      chk($sformatf("v%0d_m2r", i),   mem_to_reg_wb,  vecs[i].e_m2r);
      chk($sformatf("v%0d_rd", i),    rd_WB,          vecs[i].e_rd);
      chk($sformatf("v%0d_alu", i),   alu_res_wb,     vecs[i].e_alu);
      chk($sformatf("v%0d_wdr", i),   write_data_reg, vecs[i].e_wdr);
      chk($sformatf("v%0d_align", i), align_err,      vecs[i].e_align);
      chk($sformatf("v%0d_req", i),   bus.dmem_req,   0);
      chk($sformatf("v%0d_bus", i),   bus_err,        0);
    end
    bus.dmem_ack = 1'b0;
    chk("idle_ack_rdata", read_data_wb, 0);

    // load, ack after 3 waiting cycles: stall 4 cycles
    drive_op(32'h0000_0100, 32'h0, 5'd8, 3'b010, 2'b11, 1'b0);
    bus.dmem_rdata = 32'hDEAD_BEEF;
    #1;
    chk("ld_stall0", stall_mem, 1);
    chk("ld_req0",   bus.dmem_req, 0);
    tick();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("ld_stall_w%0d", k), stall_mem,     1);
      chk($sformatf("ld_req_w%0d", k),   bus.dmem_req,  1);
      chk($sformatf("ld_addr_w%0d", k),  bus.dmem_addr, 32'h0000_0100);
      chk($sformatf("ld_we_w%0d", k),    bus.dmem_we,   0);
      chk($sformatf("ld_wb_w%0d", k),    wb_WB,         0);
      tick();
    end
    bus.dmem_ack = 1'b1;
    #1;
    chk("ld_stall_ack", stall_mem, 0);
    tick();
    bus.dmem_ack = 1'b0;
    drive_nop();
    chk("ld_wb",    wb_WB,          1);
    chk("ld_m2r",   mem_to_reg_wb,  1);
    chk("ld_rd",    rd_WB,          8);
    chk("ld_rdata", read_data_wb,   32'hDEAD_BEEF);
    chk("ld_wdr",   write_data_reg, 32'hDEAD_BEEF);
    chk("ld_req_off", bus.dmem_req, 0);
    tick();

    // store with immediate ack
    drive_op(32'h0000_0024, 32'h1234_5678, 5'd0, 3'b001, 2'b00, 1'b0);
    bus.dmem_rdata = 32'h0BAD_0BAD;
    #1;
    chk("st_stall0", stall_mem, 1);
    tick();
    chk("st_req",   bus.dmem_req,   1);
    chk("st_we",    bus.dmem_we,    1);
    chk("st_addr",  bus.dmem_addr,  32'h0000_0024);
    chk("st_wdata", bus.dmem_wdata, 32'h1234_5678);
    bus.dmem_ack = 1'b1;
    #1;
    chk("st_stall_ack", stall_mem, 0);
    tick();
    bus.dmem_ack = 1'b0;
    drive_nop();
    chk("st_req_off", bus.dmem_req, 0);
    chk("st_wb",      wb_WB,        0);
    chk("st_rdata",   read_data_wb, 32'hDEAD_BEEF);
    tick();

    // timeout: no ack, req high 16 cycles then bus_err
    drive_op(32'h0000_0200, 32'h0, 5'd9, 3'b010, 2'b11, 1'b0);
    tick();
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("to_req_%0d", k),   bus.dmem_req, 1);
      chk($sformatf("to_stall_%0d", k), stall_mem,    (k < 15) ? 1 : 0);
      chk($sformatf("to_bus_%0d", k),   bus_err,      0);
      tick();
    end
    drive_nop();
    chk("to_req_off", bus.dmem_req, 0);
    chk("to_bus_err", bus_err,      1);
    chk("to_wb",      wb_WB,        0);
    chk("to_align",   align_err,    0);
    tick();
    chk("to_bus_pulse", bus_err, 0);

    // ack on the 16th waiting cycle wins over timeout
    drive_op(32'h0000_0200, 32'h0, 5'd9, 3'b010, 2'b11, 1'b0);
    bus.dmem_rdata = 32'hCAFE_0001;
    tick();
    for (int k = 0; k < 15; k++) tick();
    chk("tw_req", bus.dmem_req, 1);
    bus.dmem_ack = 1'b1;
    #1;
    chk("tw_stall", stall_mem, 0);
    tick();
    bus.dmem_ack = 1'b0;
    drive_nop();
    chk("tw_bus",   bus_err,      0);
    chk("tw_wb",    wb_WB,        1);
    chk("tw_rd",    rd_WB,        9);
    chk("tw_rdata", read_data_wb, 32'hCAFE_0001);
    tick();

    // branch suppressed while a load is outstanding
    drive_op(32'h0000_0300, 32'h0, 5'd4, 3'b110, 2'b11, 1'b1);
    #1;
    chk("br_pc_issue", pc_src, 0);
    tick();
    drive_op(32'h0000_0300, 32'h0, 5'd4, 3'b100, 2'b00, 1'b1);
    #1;
    chk("br_pc_wait0", pc_src, 0);
    tick();
    chk("br_pc_wait1", pc_src, 0);
    bus.dmem_ack = 1'b1;
    #1;
    chk("br_pc_ack", pc_src, 1);
    tick();
    bus.dmem_ack = 1'b0;
    drive_nop();
    tick();

    // reset mid-WAIT, then a late ack
    drive_op(32'h0000_0400, 32'h7777_7777, 5'd6, 3'b001, 2'b10, 1'b0);
    tick();
    tick();
    chk("rw_req_before", bus.dmem_req, 1);
    #2;
    drive_nop();
    rst_n = 1'b0;
    #1;
    chk("rw_req",   bus.dmem_req,   0);
    chk("rw_we",    bus.dmem_we,    0);
    chk("rw_addr",  bus.dmem_addr,  0);
    chk("rw_wdata", bus.dmem_wdata, 0);
    chk("rw_wb",    wb_WB,          0);
    chk("rw_rd",    rd_WB,          0);
    chk("rw_rdata", read_data_wb,   0);
    chk("rw_alu",   alu_res_wb,     0);
    tick();
    rst_n = 1'b1;
    bus.dmem_ack   = 1'b1;
    bus.dmem_rdata = 32'h1111_2222;
    tick();
    bus.dmem_ack = 1'b0;
    chk("late_req",   bus.dmem_req, 0);
    chk("late_rdata", read_data_wb, 0);
    chk("late_bus",   bus_err,      0);
    chk("late_wb",    wb_WB,        0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- MEM pipeline stage. It consumes the EX/MEM register outputs of the execute stage: ALU result, store data, destination register, and the m/wb control bundles.
- Drives a req/ack data-memory bus and stalls the upstream pipeline while an access is outstanding.
- Produces the MEM/WB register set, plus write_data_reg/rd_WB/wb_WB, which feed back into the EX forwarding unit.
- Also resolves branch taken from m[2] & zero.

Parameters:
DATA_W, 32, data and address width
TIMEOUT, 16, max cycles in WAIT before bus error abort (>=1)
CNT_W, 5, width of timeout counter (2^CNT_W > TIMEOUT)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
res  in  DATA_W  EX/MEM ALU result; memory byte address for loads/stores
write_data_ex  in  DATA_W  EX/MEM store data
write_register_ex  in  5  EX/MEM destination register
zero  in  1  EX/MEM ALU zero flag
m_MEM  in  3  [2]=branch, [1]=mem_read, [0]=mem_write
wb_MEM  in  2  [1]=reg_write, [0]=mem_to_reg
dmem_req  out  1  access request, registered
dmem_we  out  1  1=store, 0=load; valid while dmem_req
dmem_addr  out  DATA_W  word-aligned address; valid while dmem_req
dmem_wdata  out  DATA_W  store data; valid while dmem_req
dmem_rdata  in  DATA_W  load data, sampled when dmem_ack=1
dmem_ack  in  1  one-cycle completion pulse
stall_mem  out  1  combinational; upstream registers (PC, IF/ID, ID/EX, EX/MEM) must hold
pc_src  out  1  combinational: m_MEM[2] & zero & ~stall_mem
wb_WB  out  1  MEM/WB reg_write
mem_to_reg_wb  out  1  MEM/WB mem_to_reg
rd_WB  out  5  MEM/WB destination register
read_data_wb  out  DATA_W  MEM/WB load data
alu_res_wb  out  DATA_W  MEM/WB ALU result
write_data_reg  out  DATA_W  combinational: mem_to_reg_wb ? read_data_wb : alu_res_wb
align_err  out  1  one-cycle pulse: misaligned access dropped
bus_err  out  1  one-cycle pulse: access aborted on timeout

Behaviour:
- Reset (rst_n=0, async): state=IDLE.
  - dmem_req, dmem_we, wb_WB, mem_to_reg_wb, align_err, bus_err all 0.
  - rd_WB=0, read_data_wb=0, alu_res_wb=0, dmem_addr=0, dmem_wdata=0, timeout counter=0.
- memop = m_MEM[1] | m_MEM[0]. If both bits are set, the access is a store. misaligned = res[1:0]!=0.
- State IDLE:
  - No memop: at the edge, MEM/WB <= {wb_MEM, write_register_ex, alu_res=res}; read_data_wb unchanged; stall_mem=0. Latency is 1 cycle.
  - memop & misaligned: no request issued; align_err=1 next cycle; MEM/WB gets a bubble (wb_WB=0); stall_mem=0.
  - memop & aligned:
    - stall_mem=1 and MEM/WB gets a bubble.
    - At the edge: dmem_req<=1, dmem_we<=m_MEM[0], dmem_addr<={res[DATA_W-1:2],2'b00}, dmem_wdata<=write_data_ex, counter<=0, state<=WAIT.
    - Capture wb_MEM, write_register_ex and res internally.
- State WAIT:
  - dmem_req/we/addr/wdata held stable.
  - stall_mem = ~dmem_ack.
  - Counter increments each cycle without ack.
  - On dmem_ack:
    - MEM/WB <= captured wb, rd, alu_res.
    - For a load, read_data_wb <= dmem_rdata; for a store, read_data_wb is unchanged and wb_WB = captured reg_write (0 from decode).
    - dmem_req<=0, state<=IDLE.
    - Upstream advances on this same edge.
    - Minimum load/store occupancy is 2 cycles.
  - Counter reaching TIMEOUT-1 without ack:
    - dmem_req<=0, bus_err=1 next cycle, MEM/WB bubble, state<=IDLE, stall released that cycle.
  - ack and timeout in the same cycle: ack wins and there is no bus_err.
- Stalled cycles always write a bubble into MEM/WB: wb_WB=0, mem_to_reg_wb=0. rd_WB and data are don't-care but held.
- dmem_ack while in IDLE is ignored.
- dmem_req is never asserted on consecutive accesses without an intervening IDLE cycle.
- pc_src is suppressed while stall_mem=1.
- Reset mid-WAIT: dmem_req drops immediately. A late ack after reset is ignored.
- align_err and bus_err are single-cycle pulses. They are mutually exclusive by construction.

Test Plan:
- ALU passthrough: res=0x0000_0010, rd=5, wb=2'b10, m=0 → next cycle wb_WB=1, rd_WB=5, write_data_reg=0x10, stall_mem=0, dmem_req never 1.
- Load with ack after 3 cycles: res=0x100, m=3'b010, wb=2'b11, rd=8, dmem_rdata=0xDEAD_BEEF:
  - stall_mem=1 for 4 cycles, dmem_addr=0x100, dmem_we=0.
  - After ack: wb_WB=1, rd_WB=8, write_data_reg=0xDEAD_BEEF.
- Store, immediate ack: res=0x24, write_data_ex=0x1234_5678, m=3'b001 → dmem_we=1, dmem_wdata=0x1234_5678 for exactly 1 cycle, stall_mem high 1 cycle; wb_WB=0.
- Misaligned load at res=0x102 → no dmem_req, align_err pulse, wb_WB=0, no stall.
- Timeout (TIMEOUT=16), load with no ack → dmem_req high 16 cycles, then bus_err pulse, wb_WB=0, stall released. Repeat with ack in cycle 16 → ack wins, no bus_err.
- Branch: m=3'b100, zero=1 → pc_src=1. Same with an outstanding load ahead (stall) → pc_src=0 until the stall clears. Reset asserted mid-WAIT → dmem_req=0 asynchronously and all outputs at reset values.
